// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin arbiter for the single register-file write port.
// Two writeback requesters (req0 = ALU, req1 = load unit) compete through a
// valid/ready handshake; the winner's address/data are registered onto A3/WD3
// one cycle later. Writes to $0 complete the handshake but never raise WE3.
// Ports:
//   clk, rst (async, active low), wr_stall (blocks all grants)
//   reqN_valid/reqN_addr/reqN_data in, reqN_ready out (combinational grant)
//   A3/WD3/WE3 registered register-file write port, grant_id = source of A3/WD3
module regfile_wr_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_stall,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic [AW-1:0] A3,
  output logic [DW-1:0] WD3,
  output logic          WE3,
  output logic          grant_id
);
  logic          ptr_q, ptr_d;
  logic [AW-1:0] a3_q, a3_d;
  logic [DW-1:0] wd3_q, wd3_d;
  logic          we3_q, we3_d;
  logic          gid_q, gid_d;
  logic          gnt0, gnt1, xfer;
  // rst gates the grants so both readies read 0 while reset is held.
  // ptr only breaks ties; a lone valid requester always wins.
  always_comb begin
    gnt0  = rst && !wr_stall && req0_valid && (!req1_valid || !ptr_q);
    gnt1  = rst && !wr_stall && req1_valid && (!req0_valid || ptr_q);
    xfer  = gnt0 || gnt1;
    a3_d  = xfer ? (gnt1 ? req1_addr : req0_addr) : a3_q;
    wd3_d = xfer ? (gnt1 ? req1_data : req0_data) : wd3_q;
    we3_d = xfer && (a3_d != '0);
    gid_d = xfer ? gnt1 : gid_q;
    ptr_d = xfer ? gnt0 : ptr_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
      we3_q <= 1'b0;
      gid_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      a3_q  <= a3_d;
      wd3_q <= wd3_d;
      we3_q <= we3_d;
      gid_q <= gid_d;
    end
  end
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign A3         = a3_q;
  assign WD3        = wd3_q;
  assign WE3        = we3_q;
  assign grant_id   = gid_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: scoreboard bench with a transaction-level reference model.
module tb_regfile_wr_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_stall = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0]  req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready, WE3, grant_id;
  logic [4:0]  A3;
  logic [31:0] WD3;

  regfile_wr_arbiter #(.AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst_n), .wr_stall(wr_stall),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .A3(A3), .WD3(WD3), .WE3(WE3), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r0, r1, we, gid;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, failures = 0;
  logic [31:0] dut_rf[32];
  logic [31:0] ref_rf[32];
  // reference state: who gets the tie next, and the last accepted write
  int          m_next = 0;
  logic [4:0]  m_a = '0;
  logic [31:0] m_d = '0;
  int          m_id = 0;
  // requester-side pending writes for the randomized phases
  logic        p0 = 1'b0, p1 = 1'b0;
  logic [4:0]  pa0 = '0, pa1 = '0;
  logic [31:0] pd0 = '0, pd1 = '0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // monitor: readies checked mid-low-phase, registered outputs just after the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("req0_ready", 64'(req0_ready), 64'(e.r0));
        chk("req1_ready", 64'(req1_ready), 64'(e.r1));
        @(posedge clk);
        #1;
        chk("WE3", 64'(WE3), 64'(e.we));
        chk("A3", 64'(A3), 64'(e.a));
        chk("WD3", 64'(WD3), 64'(e.d));
        chk("grant_id", 64'(grant_id), 64'(e.gid));
        if (WE3 === 1'b1) dut_rf[A3] = WD3;
      end
    end
  end

  // one clock of stimulus; the model decides the winner from the arbitration rules
  task automatic cycle(input logic st, input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       output logic g0, output logic g1);
    exp_t e;
    int   win;
    @(negedge clk);
    wr_stall = st;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #1;
    if (!rst_n) begin
      m_next = 0; m_a = '0; m_d = '0; m_id = 0;
    end
    win = -1;
    if (rst_n && !st) begin
      if (v0 && v1) win = m_next;
      else if (v0) win = 0;
      else if (v1) win = 1;
    end
    g0 = (win == 0);
    g1 = (win == 1);
    e.r0 = g0;
    e.r1 = g1;
    e.we = 1'b0;
    if (win >= 0) begin
      m_a = (win == 1) ? a1 : a0;
      m_d = (win == 1) ? d1 : d0;
      m_id = win;
      m_next = 1 - win;
      e.we = (m_a != 0);
      if (m_a != 0) ref_rf[m_a] = m_d;
    end
    e.a = rst_n ? m_a : 5'd0;
    e.d = rst_n ? m_d : 32'd0;
    e.gid = (m_id == 1);
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    logic g0, g1;
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, g0, g1);
  endtask

  // requesters obeying the handshake: payload held until granted
  task automatic engine(input int n, input int stall_pct, input int new_pct);
    logic g0, g1;
    for (int i = 0; i < n; i++) begin
      if (!p0 && $urandom_range(99) < new_pct) begin
        p0 = 1'b1; pa0 = 5'($urandom_range(0, 7)); pd0 = $urandom;
      end
      if (!p1 && $urandom_range(99) < new_pct) begin
        p1 = 1'b1; pa1 = 5'($urandom_range(0, 7)); pd1 = $urandom;
      end
      cycle($urandom_range(99) < stall_pct, p0, pa0, pd0, p1, pa1, pd1, g0, g1);
      if (g0) p0 = 1'b0;
      if (g1) p1 = 1'b0;
    end
  endtask

  initial begin
    logic g0, g1;
    for (int i = 0; i < 32; i++) begin
      dut_rf[i] = '0;
      ref_rf[i] = '0;
    end
    // reset held with both valid: nothing granted, outputs zero
    cycle(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, g0, g1);
    cycle(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, g0, g1);
    rst_n = 1'b1;
    // contention on $3: req0 first, req1 last and wins
    cycle(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, g0, g1);
    chk("first_grant_req0", 64'(g0), 64'd1);
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h22, g0, g1);
    idle();
    chk("reg3_final", 64'(dut_rf[3]), 64'h22);
    // lone requester 1
    cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, g0, g1);
    idle();
    idle();
    // write to $0 consumed but not performed
    cycle(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, g0, g1);
    idle();
    // stall with both valid, then resume at the saved pointer
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 5'd7, 32'hAA, 1'b1, 5'd8, 32'hBB, g0, g1);
    cycle(1'b0, 1'b1, 5'd7, 32'hAA, 1'b1, 5'd8, 32'hBB, g0, g1);
    chk("resume_req1", 64'(g1), 64'd1);
    cycle(1'b0, 1'b1, 5'd7, 32'hAA, 1'b0, 5'd0, 32'h0, g0, g1);
    // back-to-back with fresh nonzero requests, then async reset between edges
    for (int i = 0; i < 8; i++) begin
      if (!p0) begin p0 = 1'b1; pa0 = 5'($urandom_range(1, 31)); pd0 = $urandom; end
      if (!p1) begin p1 = 1'b1; pa1 = 5'($urandom_range(1, 31)); pd1 = $urandom; end
      cycle(1'b0, p0, pa0, pd0, p1, pa1, pd1, g0, g1);
      if (g0) p0 = 1'b0;
      if (g1) p1 = 1'b0;
    end
    chk("pre_reset_we", 64'(WE3), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_we", 64'(WE3), 64'd0);
    chk("async_reset_a3", 64'(A3), 64'd0);
    engine(2, 0, 100);
    rst_n = 1'b1;
    p0 = 1'b1; p1 = 1'b1;
    cycle(1'b0, p0, pa0, pd0, p1, pa1, pd1, g0, g1);
    chk("post_reset_req0", 64'(g0), 64'd1);
    if (g0) p0 = 1'b0;
    if (g1) p1 = 1'b0;
    // randomized traffic with stalls and address collisions
    engine(400, 20, 60);
    p0 = 1'b0; p1 = 1'b0;
    idle();
    idle();
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    for (int i = 0; i < 32; i++) chk($sformatf("rf[%0d]", i), 64'(dut_rf[i]), 64'(ref_rf[i]));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Arbitrates the single register-file write port (A3/WD3/WE3) between two writeback requesters: req0 (ALU/R-type writeback) and req1 (load/long-latency unit writeback).
- Round-robin, valid/ready handshake, one registered output stage.
- Writes to register 0 are accepted and dropped, so $0 stays zero.
- Sits between the writeback sources and the register file in the MIPS core.

Parameters:
- AW, 5, register address width (32 registers)
- DW, 32, write data width

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- wr_stall  input  1  pipeline stall; blocks all grants while high
- req0_valid  input  1  requester 0 has a write pending
- req0_addr  input  AW  requester 0 destination register
- req0_data  input  DW  requester 0 write data
- req0_ready  output  1  requester 0 granted this cycle
- req1_valid  input  1  requester 1 has a write pending
- req1_addr  input  AW  requester 1 destination register
- req1_data  input  DW  requester 1 write data
- req1_ready  output  1  requester 1 granted this cycle
- A3  output  AW  register-file write address (registered)
- WD3  output  DW  register-file write data (registered)
- WE3  output  1  register-file write enable (registered)
- grant_id  output  1  requester that produced the current A3/WD3 (registered)

Behaviour:
- Reset (rst low, async): A3=0, WD3=0, WE3=0, grant_id=0, priority pointer ptr=0 (req0 preferred). req0_ready and req1_ready are forced to 0 while rst is low.
- Grant is combinational from the valids, ptr and wr_stall:
  - wr_stall=1: no grant, both readies 0.
  - Only one valid: that requester is granted.
  - Both valid: requester ptr is granted.
  - reqN_ready = granted N. Transfer occurs on the cycle where valid && ready.
- At most one transfer per cycle. Exactly one ready may be high in any cycle.
- Handshake rule: once a requester raises valid, addr and data stay stable and valid stays high until ready. Violation is a requester error; the arbiter samples addr/data on the transfer edge only.
- Output stage, latency 1 cycle:
  - On a transfer from requester N: A3<=reqN_addr, WD3<=reqN_data, grant_id<=N, WE3<=(reqN_addr!=0).
  - With no transfer: WE3<=0, A3/WD3/grant_id hold their values.
- Write to register 0: handshake completes normally (ready high, request consumed), but WE3 stays 0. A3/WD3 still update.
- ptr update: after any transfer from N, ptr<=~N. No transfer: ptr holds.
- Fairness: a requester holding valid high with wr_stall=0 is granted within 2 cycles.
- Simultaneous requests to the same register: serialized in grant order. The later-granted value is written last and wins. No merging or dropping.
- wr_stall rising mid-stream: no new transfers. The write already registered completes on its cycle (WE3 as registered). ptr is preserved.
- Reset asserted mid-operation: all outputs clear immediately and any registered pending write is lost. After release, ptr=0.
- Back-to-back: with both valids held continuously, grants alternate 0,1,0,1… and WE3 is high every cycle (non-zero addresses).

Test Plan:
- Reset: hold rst=0 with both valids high -> WE3=0, A3=0, WD3=0, both readies 0. Release rst -> req0 granted first cycle (ptr=0).
- Single requester: req1_valid=1, addr=5, data=0xDEADBEEF -> req1_ready=1 same cycle. Next cycle A3=5, WD3=0xDEADBEEF, WE3=1, grant_id=1. Following cycle WE3=0.
- Contention: both valid from reset, req0 addr=3 data=0x11, req1 addr=3 data=0x22 -> cycle1 WE3/A3=3/WD3=0x11, cycle2 WD3=0x22. Readies alternate 1/0 then 0/1. Final reg3=0x22.
- $0 write: req0 addr=0 data=0xFFFFFFFF -> req0_ready=1, next cycle A3=0, WE3=0. Register file $0 reads 0.
- Stall: both valid, wr_stall=1 for 3 cycles -> readies 0, WE3=0, ptr unchanged. Stall drop -> grant resumes at the saved ptr.
- Async reset mid-stream: assert rst low between edges during back-to-back writes -> WE3 drops to 0 immediately, not at the next edge. After release, req0 wins first.
